// File: rtl/rle_pkg.sv
// ---------------------------------------------------------------------------
// rle_pkg
// Shared constants and types for the run-length encoder slice.
//   WORD_W / NIB_W / NIBBLES : output word geometry (8 nibbles of 4 bits)
//   RUN_W / MAX_RUN          : run length field width and largest run
//   state_t                  : encoder control states
//   nibble_t                 : one encoded run {bit value, run length}
// ---------------------------------------------------------------------------
package rle_pkg;

  localparam int WORD_W  = 32;
  localparam int NIB_W   = 4;
  localparam int RUN_W   = 3;
  localparam int MAX_RUN = 7;
  localparam int NIBBLES = 8;
  localparam int IDX_W   = $clog2(NIBBLES);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    EMIT,
    FLUSH
  } state_t;

  typedef struct packed {
    logic             value;
    logic [RUN_W-1:0] run;
  } nibble_t;

endpackage

// File: rtl/rle_nibble_packer.sv
// ---------------------------------------------------------------------------
// rle_nibble_packer
// Packs nibbles into a 32-bit word, first nibble in bits 31:28, and holds the
// word on the output until the consumer takes it. Unused slots stay zero.
//   push/nib  : write nib into the next free slot
//   finish    : close the word now (zero padded) and mark it as the last one
//   fill      : combinational, high when this push occupies the final slot
//   out_*     : valid/ready handshake for the finished word
// ---------------------------------------------------------------------------
module rle_nibble_packer
  import rle_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  nibble_t           nib,
  input  logic              finish,
  output logic              fill,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WORD_W-1:0] out_data,
  output logic              out_last
);

  localparam int LSB_W = $clog2(WORD_W);

  logic [WORD_W-1:0] word_q, word_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic [LSB_W-1:0]  slot_lsb;

  // NOTE: every signal written here gets a default first; a branch that
  // skipped one would otherwise infer a latch.
  always_comb begin
    word_d   = word_q;
    idx_d    = idx_q;
    valid_d  = valid_q;
    last_d   = last_q;
    slot_lsb = LSB_W'((NIBBLES - 1 - int'(idx_q)) * NIB_W);
    fill     = push && (idx_q == IDX_W'(NIBBLES - 1));

    if (valid_q && out_ready) begin
      word_d  = '0;
      idx_d   = '0;
      valid_d = 1'b0;
      last_d  = 1'b0;
    end else begin
      if (push) begin
        word_d[slot_lsb +: NIB_W] = nib;
        // Wraps to 0 on the eighth push; valid_q marks the word as full.
        idx_d = idx_q + IDX_W'(1);
      end
      if (fill || finish) valid_d = 1'b1;
      if (finish)         last_d  = 1'b1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_q  <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      word_q  <= word_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = word_q;
  assign out_last  = last_q;

endmodule

// File: rtl/rle_encoder.sv
// ---------------------------------------------------------------------------
// rle_encoder
// Run-length encoder for the ODE-solver host link. Fields are serialised MSB
// first, one bit per cycle; runs of up to 7 equal bits become nibbles
// {bit, run} which rle_nibble_packer assembles into 32-bit words.
//   in_valid/in_ready/in_data/in_len : field input (right aligned, len 0..FIELD_W)
//   flush                            : close the run and emit a padded last word
//   out_valid/out_ready/out_data/out_last : word output handshake
//   busy                             : activity or pending flush
//   total_bits                       : encoded-bit counter, built only when
//                                      RLE_BITCOUNT_EN is defined, else 0
// ---------------------------------------------------------------------------
module rle_encoder
  import rle_pkg::*;
#(
  parameter int FIELD_W = 16,
  parameter int LEN_W   = $clog2(FIELD_W) + 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [FIELD_W-1:0] in_data,
  input  logic [LEN_W-1:0]   in_len,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WORD_W-1:0]  out_data,
  output logic               out_last,
  output logic               busy,
  output logic [31:0]        total_bits
);

  state_t             state_q, state_d;
  logic [FIELD_W-1:0] data_q, data_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic               run_bit_q, run_bit_d;
  logic [RUN_W-1:0]   run_cnt_q, run_cnt_d;
  logic               flush_pend_q, flush_pend_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;

  logic               push, finish, fill, cur_bit;
  nibble_t            nib;
  logic [LEN_W-1:0]   len_c;

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    cnt_d        = cnt_q;
    run_bit_d    = run_bit_q;
    run_cnt_d    = run_cnt_q;
    flush_pend_d = flush_pend_q;
    push         = 1'b0;
    finish       = 1'b0;
    nib          = '{value: run_bit_q, run: run_cnt_q};
    len_c        = (in_len > LEN_W'(FIELD_W)) ? LEN_W'(FIELD_W) : in_len;
    cur_bit      = data_q[FIELD_W-1];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Left-align the field so the shifter always reads the top bit.
          data_d = in_data << (LEN_W'(FIELD_W) - len_c);
          cnt_d  = len_c;
          if (len_c == '0) begin
            state_d = flush ? FLUSH : IDLE;
          end else begin
            state_d      = SHIFT;
            flush_pend_d = flush;
          end
        end else if (flush) begin
          state_d = FLUSH;
        end
      end

      SHIFT: begin
        if (flush) flush_pend_d = 1'b1;
        data_d = data_q << 1;
        cnt_d  = cnt_q - LEN_W'(1);
        if (run_cnt_q == '0) begin
          run_bit_d = cur_bit;
          run_cnt_d = RUN_W'(1);
        end else if (cur_bit == run_bit_q && run_cnt_q != RUN_W'(MAX_RUN)) begin
          run_cnt_d = run_cnt_q + RUN_W'(1);
        end else begin
          push      = 1'b1;
          run_bit_d = cur_bit;
          run_cnt_d = RUN_W'(1);
        end
        // A full word stalls the remaining bits; cnt_q remembers where to resume.
        if (fill)                       state_d = EMIT;
        else if (cnt_q == LEN_W'(1))    state_d = flush_pend_d ? FLUSH : IDLE;
      end

      EMIT: begin
        if (out_valid && out_ready) begin
          if (out_last)           state_d = IDLE;
          else if (cnt_q != '0)   state_d = SHIFT;
          else if (flush_pend_q)  state_d = FLUSH;
          else                    state_d = IDLE;
        end
      end

      FLUSH: begin
        // Closing the run may itself fill the word; either way exactly one
        // word leaves with out_last set.
        push         = (run_cnt_q != '0);
        finish       = 1'b1;
        run_bit_d    = 1'b0;
        run_cnt_d    = '0;
        flush_pend_d = 1'b0;
        state_d      = EMIT;
      end

      default: state_d = IDLE;
    endcase

    in_ready_d = (state_d == IDLE);
    busy_d     = (state_d != IDLE) || flush_pend_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      data_q       <= '0;
      cnt_q        <= '0;
      run_bit_q    <= 1'b0;
      run_cnt_q    <= '0;
      flush_pend_q <= 1'b0;
      in_ready_q   <= 1'b1;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      data_q       <= data_d;
      cnt_q        <= cnt_d;
      run_bit_q    <= run_bit_d;
      run_cnt_q    <= run_cnt_d;
      flush_pend_q <= flush_pend_d;
      in_ready_q   <= in_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign busy     = busy_q;

  rle_nibble_packer u_packer (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .nib       (nib),
    .finish    (finish),
    .fill      (fill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

`ifdef RLE_BITCOUNT_EN
  logic [31:0] total_q, total_d;

  always_comb begin
    total_d = total_q;
    if (state_q == SHIFT)                  total_d = total_q + 32'd1;
    if (out_valid && out_ready && out_last) total_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) total_q <= '0;
    else     total_q <= total_d;
  end

  assign total_bits = total_q;
`else
  assign total_bits = '0;
`endif

endmodule

// File: tb/tb_rle_encoder.sv
// ---------------------------------------------------------------------------
// tb_rle_encoder
// Directed and randomized checks of rle_encoder. Expected words come from a
// reference model that turns the serialised bit stream into greedy runs of at
// most 7, then packs 8 nibbles per word with the final word marked last.
// ---------------------------------------------------------------------------
module tb_rle_encoder;

  localparam int FIELD_W = 16;
  localparam int LEN_W   = 5;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [FIELD_W-1:0] in_data;
  logic [LEN_W-1:0]   in_len;
  logic               flush;
  logic               out_valid;
  logic               out_ready;
  logic [31:0]        out_data;
  logic               out_last;
  logic               busy;
  logic [31:0]        total_bits;

  rle_encoder #(.FIELD_W(FIELD_W), .LEN_W(LEN_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_len     (in_len),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_last   (out_last),
    .busy       (busy),
    .total_bits (total_bits)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        last;
  } word_t;

  int    checks = 0;
  int    errors = 0;
  word_t got_q[$];
  word_t exp_q[$];
  bit    bits_q[$];
  bit    hold_ready = 1'b0;
  bit    rand_ready = 1'b0;
  bit    got_last   = 1'b0;

  // Consumer: picks out_ready for the coming edge and records the word that
  // edge will transfer.
  always @(negedge clk) begin
    out_ready = hold_ready ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    if (!rst && out_valid && out_ready) begin
      got_q.push_back('{out_data, out_last});
      if (out_last) got_last = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, " in_ready"},   32'(in_ready),  32'd1);
    check({tag, " out_valid"},  32'(out_valid), 32'd0);
    check({tag, " out_data"},   out_data,       32'd0);
    check({tag, " out_last"},   32'(out_last),  32'd0);
    check({tag, " busy"},       32'(busy),      32'd0);
    check({tag, " total_bits"}, total_bits,     32'd0);
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    @(negedge clk);
    bits_q.delete();
    got_q.delete();
    got_last = 1'b0;
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (in_ready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check({tag, " in_ready wait"}, 32'(in_ready), 32'd1);
  endtask

  task automatic send_field(input logic [FIELD_W-1:0] data, input int len, input bit fl);
    int l;
    wait_ready("send_field");
    l        = (len > FIELD_W) ? FIELD_W : len;
    in_valid = 1'b1;
    in_data  = data;
    in_len   = LEN_W'(len);
    flush    = fl;
    for (int i = l - 1; i >= 0; i--) bits_q.push_back(data[i]);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  task automatic send_flush();
    wait_ready("send_flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
  endtask

  task automatic begin_stream();
    got_q.delete();
    bits_q.delete();
    got_last = 1'b0;
  endtask

  // Reference model: greedy runs over the whole stream, then word packing.
  task automatic build_expected();
    logic [3:0]  nibs[$];
    logic [31:0] w;
    int          i;
    int          n;
    exp_q.delete();
    i = 0;
    while (i < bits_q.size()) begin
      n = 1;
      while (i + n < bits_q.size() && bits_q[i + n] == bits_q[i] && n < 7) n++;
      nibs.push_back({bits_q[i], 3'(n)});
      i += n;
    end
    if (nibs.size() == 0) begin
      exp_q.push_back('{32'h0, 1'b1});
    end else begin
      for (int k = 0; k < nibs.size(); k += 8) begin
        w = '0;
        for (int j = 0; j < 8; j++)
          if (k + j < nibs.size()) w[31 - 4 * j -: 4] = nibs[k + j];
        exp_q.push_back('{w, 1'(k + 8 >= nibs.size())});
      end
    end
    bits_q.delete();
  endtask

  task automatic finish_stream(input string tag);
    int n = 0;
    while (!got_last && n < 3000) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    check({tag, " last seen"}, 32'(got_last), 32'd1);
    build_expected();
    check({tag, " word count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        check($sformatf("%s w%0d data", tag, i), got_q[i].data,       exp_q[i].data);
        check($sformatf("%s w%0d last", tag, i), 32'(got_q[i].last), 32'(exp_q[i].last));
      end
    end
    check({tag, " busy idle"}, 32'(busy), 32'd0);
    check({tag, " bits cleared"}, total_bits, 32'd0);
  endtask

  function automatic logic [31:0] exp_count(input int n);
`ifdef RLE_BITCOUNT_EN
    return 32'(n);
`else
    return 32'd0 & 32'(n);
`endif
  endfunction

  initial begin
    logic [31:0] held;
    int          n;
    int          nf;
    int          len;
    int          sum;
    bit          co;

    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    in_len    = '0;
    flush     = 1'b0;
    out_ready = 1'b1;

    // Reset state.
    do_reset();

    // Mixed runs: 000 1 0 1 -> 0x3919_0000.
    begin_stream();
    send_field(16'b000101, 6, 1'b0);
    send_flush();
    finish_stream("f000101");
    check("f000101 const", got_q.size() > 0 ? got_q[0].data : 32'hx, 32'h3919_0000);

    // Long run split at MAX_RUN: 7,7,2 ones.
    begin_stream();
    send_field(16'hFFFF, 16, 1'b0);
    send_flush();
    finish_stream("fFFFF");
    check("fFFFF const", got_q.size() > 0 ? got_q[0].data : 32'hx, 32'hFFA0_0000);

    // Alternating bits fill two words; the flush closes the second.
    begin_stream();
    send_field(16'hAAAA, 16, 1'b0);
    wait_ready("fAAAA done");
    check("fAAAA total_bits", total_bits, exp_count(16));
    send_flush();
    finish_stream("fAAAA");
    check("fAAAA w0 const", got_q.size() > 1 ? got_q[0].data : 32'hx, 32'h9191_9191);
    check("fAAAA w1 const", got_q.size() > 1 ? got_q[1].data : 32'hx, 32'h9191_9191);

    // Same field with the consumer stalled on the first word.
    begin_stream();
    hold_ready = 1'b1;
    send_field(16'hAAAA, 16, 1'b0);
    n = 0;
    while (out_valid !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("stall valid", 32'(out_valid), 32'd1);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check($sformatf("stall c%0d valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stall c%0d data", i),  out_data,       held);
      check($sformatf("stall c%0d in_ready", i), 32'(in_ready), 32'd0);
    end
    hold_ready = 1'b0;
    send_flush();
    finish_stream("stall");
    check("stall w1 const", got_q.size() > 1 ? got_q[1].data : 32'hx, 32'h9191_9191);

    // Flush with nothing pending, straight from reset.
    do_reset();
    begin_stream();
    send_flush();
    finish_stream("empty");
    check("empty const", got_q.size() > 0 ? got_q[0].data : 32'hx, 32'h0);

    // Zero-length field is a no-op.
    begin_stream();
    send_field(16'h1234, 0, 1'b0);
    @(negedge clk);
    check("len0 in_ready", 32'(in_ready), 32'd1);
    check("len0 busy", 32'(busy), 32'd0);
    check("len0 no word", 32'(got_q.size()), 32'd0);

    // Reset after 5 of 16 bits, then a clean stream.
    begin_stream();
    send_field(16'hFFFF, 16, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    check_reset_vals("midfield");
    do_reset();
    begin_stream();
    send_field(16'b000101, 6, 1'b0);
    send_flush();
    finish_stream("after_rst");
    check("after_rst const", got_q.size() > 0 ? got_q[0].data : 32'hx, 32'h3919_0000);

    // Randomized streams with random backpressure and clamped lengths.
    rand_ready = 1'b1;
    for (int s = 0; s < 25; s++) begin
      begin_stream();
      nf  = $urandom_range(0, 4);
      sum = 0;
      co  = 1'b0;
      for (int f = 0; f < nf; f++) begin
        len = $urandom_range(0, 20);
        sum += (len > FIELD_W) ? FIELD_W : len;
        co  = (f == nf - 1) && ($urandom_range(0, 1) == 1);
        send_field(FIELD_W'($urandom), len, co);
      end
      if (!co) begin
        wait_ready($sformatf("rand%0d done", s));
        check($sformatf("rand%0d total_bits", s), total_bits, exp_count(sum));
        send_flush();
      end
      finish_stream($sformatf("rand%0d", s));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rle_encoder.md
Name: rle_encoder

Overview:
- Run-length encoder for the ODE-solver host link. It is the transmit-side counterpart of the IO loader's run-length decoder.
- Accepts right-aligned bit fields (n, m, mode, matrix elements, results), serialises each field MSB first, and packs runs into 32-bit words.
- Each word holds 8 nibbles {bit, run[2:0]}, first nibble in bits 31:28.
- A run of 0 means an empty nibble. The decoder ignores empty nibbles, so zero padding is legal.

Parameters:
- FIELD_W, 16: maximum field width in bits.
- LEN_W, $clog2(FIELD_W)+1: width of in_len.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- in_valid  in  1  field offered.
- in_ready  out  1  encoder can accept a field.
- in_data  in  FIELD_W  field bits, right-aligned.
- in_len  in  LEN_W  number of valid bits (0..FIELD_W).
- flush  in  1  terminate stream; emit pending run and padded last word.
- out_valid  out  1  out_data holds a complete word.
- out_ready  in  1  consumer takes word.
- out_data  out  32  encoded word.
- out_last  out  1  word is final word of a flush.
- busy  out  1  high when state != IDLE or a flush is pending.
- total_bits  out  32  optional counter (see Optional Feature).

Behaviour:
- Reset: state IDLE. Run register, word register and nibble index cleared. in_ready=1, out_valid=0, out_data=0, out_last=0, busy=0, total_bits=0.
- States:
  - IDLE: in_ready=1.
  - SHIFT: one bit per cycle.
  - EMIT: out_valid=1, waiting for out_ready.
  - FLUSH: close run, pad word.
- Field accept: in_valid&&in_ready in IDLE latches in_data and in_len. in_len>FIELD_W is clamped to FIELD_W.
  - in_len=0: return to IDLE next cycle, no effect.
  - Otherwise go to SHIFT.
- SHIFT bit order: bit in_len-1 down to bit 0, one per cycle. Each bit b is handled as follows:
  - run_cnt==0: run_bit=b, run_cnt=1.
  - b==run_bit and run_cnt<7: run_cnt+1.
  - Otherwise: push nibble {run_bit, run_cnt} at the next nibble slot (31:28 first), then run_bit=b, run_cnt=1.
- Word full: if the push fills slot 8, go to EMIT after that bit, stalling the remaining bits. The run register keeps the new bit.
- Field done: after the last bit, go to IDLE, or to FLUSH if a flush is pending. The run stays open across fields.
- Throughput: a field accepted at cycle T encodes bits in T+1..T+in_len. in_ready returns at T+in_len+1 plus any EMIT stall.
- EMIT:
  - out_data is stable while out_valid=1.
  - On out_valid&&out_ready the word register and nibble index clear; the next cycle resumes SHIFT, or returns to IDLE if the last field was done and no flush is pending.
  - out_last is high only on the word emitted by FLUSH.
- Flush request:
  - Sampled when in IDLE, or while shifting a field; a flush raised mid-field is held pending.
  - A flush coincident with in_valid in IDLE: the field is accepted first and the flush is held pending.
- FLUSH sequence:
  - If run_cnt>0, push the run (which may fill the word).
  - Emit exactly one word with out_last=1, with unused slots = 0.
  - If no nibbles and no run are pending, emit 0x0000_0000 with out_last=1.
  - If closing the run completes a word, that word carries out_last=1.
  - After the handshake, run and word state are clear and the block returns to IDLE.
- Reset mid-operation aborts immediately to reset values. A partial word is discarded.

Optional Feature:
- Macro RLE_BITCOUNT_EN.
- Defined: total_bits increments by 1 per encoded bit, wraps at 2^32, and clears on the flush handshake and on reset.
- Undefined: total_bits is tied to 0 and no counter logic is built.

Decomposition:
- Package rle_pkg holds:
  - Constants WORD_W=32, NIB_W=4, RUN_W=3, MAX_RUN=7, NIBBLES=8.
  - State enum {IDLE, SHIFT, EMIT, FLUSH}.
  - Nibble struct {bit, run}.
- Sub-module rle_nibble_packer: nibble push, slot index, full flag, zero-padding and out handshake. The parent holds the field shifter, run tracking and FSM.

Test Plan:
- Field 0b000101 (len 6), then flush -> one word 0x3919_0000, out_last=1.
- Field 0xFFFF (len 16), then flush -> 0xFFA0_0000 (runs 7,7,2 of 1), out_last=1.
- Field 0xAAAA (len 16), then flush -> 0x9191_9191 with last=0, then 0x9191_9191 with last=1; total_bits=16 before the flush handshake when RLE_BITCOUNT_EN is defined.
- Repeat the previous case with out_ready=0 for 10 cycles on the first word -> out_valid held, out_data stable, in_ready=0, and the second word is still correct.
- Flush from reset with nothing pending -> a single word 0x0000_0000 with last=1. A field with in_len=0 -> no word, in_ready high two cycles later.
- Assert rst mid-field (after 5 of 16 bits) -> outputs at reset values. Then field 0b000101 plus flush -> 0x3919_0000, last=1.
